// File: rtl/game_round_ctrl_pkg.sv
// rtl/game_round_ctrl_pkg.sv - shared state encoding and key constants for the round sequencer
package game_round_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRAW  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam logic [3:0] KEY_RESTART = 4'hF;

endpackage

// File: rtl/game_round_ctrl_bcd_inc2.sv
// rtl/game_round_ctrl_bcd_inc2.sv - two-digit BCD incrementer saturating at 99
module bcd_inc2 (
  input  logic [7:0] bcd_in,
  output logic [7:0] bcd_out
);

  always_comb begin
    bcd_out = bcd_in;
    if (bcd_in == 8'h99) begin
      bcd_out = 8'h99;
    end else if (bcd_in[3:0] == 4'd9) begin
      bcd_out = {bcd_in[7:4] + 4'd1, 4'd0};
    end else begin
      bcd_out = {bcd_in[7:4], bcd_in[3:0] + 4'd1};
    end
  end

endmodule

// File: rtl/game_round_ctrl.sv
// rtl/game_round_ctrl.sv - game round sequencer: draw handshake, response timing, score/lives/rounds
module game_round_ctrl
  import game_round_ctrl_pkg::*;
#(
  parameter int ROUND_TICKS = 3,
  parameter int MAX_ROUNDS  = 20,
  parameter int LIVES_INIT  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] key,
  input  logic       pressed,
  input  logic [3:0] key_random,
  input  logic       finish_ram,
  output logic       start_ram,
  output logic       finish,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic [7:0] round_cnt,
  output logic       hit,
  output logic       miss,
  output logic [2:0] state
);

  localparam logic [1:0] LIVES_RST   = 2'(LIVES_INIT);
  localparam logic [7:0] ROUND_LIMIT = 8'(MAX_ROUNDS);
  localparam logic [3:0] TICK_LIMIT  = 4'(ROUND_TICKS);

  state_t     state_q, state_d;
  logic [3:0] timer, timer_d;
  logic       pressed_d;
  logic       press_rise;
  logic [7:0] score_inc, score_d, round_d;
  logic [1:0] lives_d, lives_dec;
  logic       hit_d, miss_d;

  assign press_rise = pressed & ~pressed_d;
  assign lives_dec  = (lives == 2'd0) ? 2'd0 : lives - 2'd1;
  assign state      = state_q;

  bcd_inc2 u_bcd_inc2 (
    .bcd_in  (score),
    .bcd_out (score_inc)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer;
    score_d = score;
    lives_d = lives;
    round_d = round_cnt;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press_rise) begin
          score_d = 8'h00;
          round_d = 8'd0;
          lives_d = LIVES_RST;
          state_d = ST_DRAW;
        end
      end
      ST_DRAW: begin
        if (finish_ram && start_ram) begin
          timer_d = 4'd0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A press always wins over a terminal tick arriving in the same cycle
        if (press_rise) begin
          if (key == key_random) begin
            hit_d   = 1'b1;
            score_d = score_inc;
          end else begin
            miss_d  = 1'b1;
            lives_d = lives_dec;
          end
          state_d = ST_CHECK;
        end else if (tick) begin
          if (timer + 4'd1 == TICK_LIMIT) begin
            miss_d  = 1'b1;
            lives_d = lives_dec;
            state_d = ST_CHECK;
          end else begin
            timer_d = timer + 4'd1;
          end
        end
      end
      ST_CHECK: begin
        round_d = round_cnt + 8'd1;
        if (lives == 2'd0 || round_d == ROUND_LIMIT) begin
          state_d = ST_OVER;
        end else begin
          state_d = ST_DRAW;
        end
      end
      ST_OVER: begin
        if (press_rise && key == KEY_RESTART) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      timer     <= 4'd0;
      pressed_d <= 1'b0;
      start_ram <= 1'b0;
      finish    <= 1'b0;
      score     <= 8'h00;
      lives     <= LIVES_RST;
      round_cnt <= 8'd0;
      hit       <= 1'b0;
      miss      <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer     <= timer_d;
      pressed_d <= pressed;
      start_ram <= (state_d == ST_DRAW);
      finish    <= (state_d == ST_OVER);
      score     <= score_d;
      lives     <= lives_d;
      round_cnt <= round_d;
      hit       <= hit_d;
      miss      <= miss_d;
    end
  end

endmodule

// File: tb/tb_game_round_ctrl.sv
// tb/tb_game_round_ctrl.sv - scoreboard bench for game_round_ctrl
module tb_game_round_ctrl;

  localparam int RT = 3;
  localparam int MR = 120;
  localparam int LI = 3;

  logic       clk = 1'b0;
  logic       rst, tick, pressed, finish_ram;
  logic [3:0] key, key_random;
  logic       start_ram, finish, hit, miss;
  logic [7:0] score, round_cnt;
  logic [1:0] lives;
  logic [2:0] state;

  game_round_ctrl #(.ROUND_TICKS(RT), .MAX_ROUNDS(MR), .LIVES_INIT(LI)) dut (
    .clk(clk), .rst(rst), .tick(tick), .key(key), .pressed(pressed),
    .key_random(key_random), .finish_ram(finish_ram), .start_ram(start_ram),
    .finish(finish), .score(score), .lives(lives), .round_cnt(round_cnt),
    .hit(hit), .miss(miss), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       hit;
    logic       miss;
    logic [7:0] score;
    logic [1:0] lives;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  checks = 0;
  int  errors = 0;
  int  m_score, m_lives, m_rounds;

  always @(posedge clk) begin
    ev_t e;
    #2;
    if (hit || miss) begin
      e.hit = hit; e.miss = miss; e.score = score; e.lives = lives;
      obs_q.push_back(e);
    end
  end

  function automatic logic [7:0] to_bcd(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_key(logic [3:0] k);
    key = k; pressed = 1'b1;
    cyc(2);
    pressed = 1'b0;
    cyc(1);
  endtask

  task automatic draw_done;
    finish_ram = 1'b1;
    cyc(1);
    finish_ram = 1'b0;
  endtask

  task automatic pulse_tick;
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
  endtask

  task automatic model_new_game;
    m_score = 0; m_lives = LI; m_rounds = 0;
  endtask

  task automatic model_push(logic is_hit);
    ev_t e;
    if (is_hit) m_score = (m_score >= 99) ? 99 : m_score + 1;
    else if (m_lives > 0) m_lives = m_lives - 1;
    e.hit = is_hit; e.miss = ~is_hit; e.score = to_bcd(m_score); e.lives = 2'(m_lives);
    exp_q.push_back(e);
  endtask

  // One full round from DRAW: handshake, press, then scoreboard and round bookkeeping
  task automatic play_round(logic [3:0] k, string name);
    ev_t o, e;
    draw_done;
    model_push(k == key_random);
    press_key(k);
    m_rounds++;
    for (int i = 0; i < 20 && obs_q.size() == 0; i++) cyc(1);
    checks++;
    if (obs_q.size() == 0 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s event: observed none, required hit=%0b miss=%0b", name, ~k[0] | k[0], 1'b0);
      exp_q.delete();
    end else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      if (o !== e) begin
        errors++;
        $display("FAIL %s event: got hit=%0b miss=%0b score=%h lives=%0d, want hit=%0b miss=%0b score=%h lives=%0d",
                 name, o.hit, o.miss, o.score, o.lives, e.hit, e.miss, e.score, e.lives);
      end
    end
    checks++;
    if (round_cnt !== 8'(m_rounds)) begin
      errors++;
      $display("FAIL %s round_cnt: got %0d want %0d", name, round_cnt, m_rounds);
    end
    checks++;
    if (m_lives == 0 || m_rounds == MR) begin
      if (state !== 3'd4 || finish !== 1'b1) begin
        errors++;
        $display("FAIL %s over: got state=%0d finish=%0b want 4/1", name, state, finish);
      end
    end else if (state !== 3'd1 || start_ram !== 1'b1) begin
      errors++;
      $display("FAIL %s next_draw: got state=%0d start_ram=%0b want 1/1", name, state, start_ram);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; tick = 1'b0; pressed = 1'b0; finish_ram = 1'b0; key = 4'h0; key_random = 4'h5;
    cyc(3);
    rst = 1'b0;
    cyc(1);
    checks++;
    if ({state, start_ram, finish, score, lives, round_cnt, hit, miss} !==
        {3'd0, 1'b0, 1'b0, 8'h00, 2'(LI), 8'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: got state=%0d start=%0b fin=%0b score=%h lives=%0d rnd=%0d hit=%0b miss=%0b, want 0/0/0/00/%0d/0/0/0",
               state, start_ram, finish, score, lives, round_cnt, hit, miss, LI);
    end
  endtask

  task automatic test_draw_handshake;
    press_key(4'h0);
    model_new_game;
    checks++;
    if (state !== 3'd1 || start_ram !== 1'b1) begin
      errors++;
      $display("FAIL idle_to_draw: got state=%0d start_ram=%0b want 1/1", state, start_ram);
    end
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      checks++;
      if (start_ram !== 1'b1 || state !== 3'd1) begin
        errors++;
        $display("FAIL draw_hold[%0d]: got state=%0d start_ram=%0b want 1/1", i, state, start_ram);
      end
    end
    draw_done;
    checks++;
    if (state !== 3'd2 || start_ram !== 1'b0) begin
      errors++;
      $display("FAIL draw_done: got state=%0d start_ram=%0b want 2/0", state, start_ram);
    end
  endtask

  task automatic test_hit;
    ev_t o, e;
    model_push(1'b1);
    press_key(4'h5);
    m_rounds++;
    for (int i = 0; i < 20 && obs_q.size() == 0; i++) cyc(1);
    checks++;
    if (obs_q.size() != 1) begin
      errors++;
      $display("FAIL first_hit pulses: got %0d want 1", obs_q.size());
      obs_q.delete(); exp_q.delete();
    end else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      if (o !== e || o.score !== 8'h01) begin
        errors++;
        $display("FAIL first_hit: got hit=%0b score=%h want hit=1 score=01", o.hit, o.score);
      end
    end
    checks++;
    if (round_cnt !== 8'd1 || state !== 3'd1) begin
      errors++;
      $display("FAIL first_hit round: got rnd=%0d state=%0d want 1/1", round_cnt, state);
    end
  endtask

  task automatic test_bcd_and_max_rounds;
    while (m_rounds < 10) play_round(4'h5, "bcd_hit");
    checks++;
    if (score !== 8'h10) begin
      errors++;
      $display("FAIL bcd_carry: got %h want 10", score);
    end
    while (m_rounds < MR) play_round(4'h5, "sat_hit");
    checks++;
    if (score !== 8'h99 || round_cnt !== 8'(MR)) begin
      errors++;
      $display("FAIL bcd_saturate: got score=%h rnd=%0d want 99/%0d", score, round_cnt, MR);
    end
    press_key(4'hF);
    checks++;
    if (state !== 3'd0 || finish !== 1'b0) begin
      errors++;
      $display("FAIL restart_after_max: got state=%0d finish=%0b want 0/0", state, finish);
    end
  endtask

  task automatic test_lives;
    press_key(4'h0);
    model_new_game;
    key_random = 4'h7;
    for (int i = 0; i < 3; i++) play_round(4'h2, "wrong_key");
    checks++;
    if (lives !== 2'd0 || finish !== 1'b1) begin
      errors++;
      $display("FAIL lives_out: got lives=%0d finish=%0b want 0/1", lives, finish);
    end
    press_key(4'h3);
    checks++;
    if (state !== 3'd4 || finish !== 1'b1 || obs_q.size() != 0) begin
      errors++;
      $display("FAIL over_ignore: got state=%0d finish=%0b pulses=%0d want 4/1/0", state, finish, obs_q.size());
    end
    press_key(4'hF);
    checks++;
    if (state !== 3'd0 || finish !== 1'b0) begin
      errors++;
      $display("FAIL over_restart: got state=%0d finish=%0b want 0/0", state, finish);
    end
  endtask

  task automatic test_timeout;
    ev_t o, e;
    press_key(4'h0);
    model_new_game;
    key_random = 4'h5;
    draw_done;
    pulse_tick; cyc(1); pulse_tick; cyc(1);
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL early_timeout: got %0d pulses want 0", obs_q.size());
      obs_q.delete();
    end
    model_push(1'b0);
    pulse_tick;
    cyc(1);
    m_rounds++;
    checks++;
    if (obs_q.size() != 1) begin
      errors++;
      $display("FAIL timeout pulses: got %0d want 1", obs_q.size());
      obs_q.delete(); exp_q.delete();
    end else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      if (o !== e) begin
        errors++;
        $display("FAIL timeout: got hit=%0b miss=%0b lives=%0d want miss lives=%0d", o.hit, o.miss, o.lives, e.lives);
      end
    end
    checks++;
    if (state !== 3'd1 || round_cnt !== 8'd1) begin
      errors++;
      $display("FAIL timeout round: got state=%0d rnd=%0d want 1/1", state, round_cnt);
    end
    draw_done;
    pulse_tick; pulse_tick;
    model_push(1'b1);
    key = 4'h5; pressed = 1'b1; tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(1);
    pressed = 1'b0;
    cyc(3);
    m_rounds++;
    checks++;
    if (obs_q.size() != 1) begin
      errors++;
      $display("FAIL press_vs_tick pulses: got %0d want 1", obs_q.size());
      obs_q.delete(); exp_q.delete();
    end else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      if (o !== e) begin
        errors++;
        $display("FAIL press_vs_tick: got hit=%0b miss=%0b score=%h lives=%0d want hit=1 score=%h lives=%0d",
                 o.hit, o.miss, o.score, o.lives, e.score, e.lives);
      end
    end
  endtask

  task automatic test_reset_mid_draw;
    checks++;
    if (state !== 3'd1 || start_ram !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst_draw: got state=%0d start_ram=%0b want 1/1", state, start_ram);
    end
    rst = 1'b1;
    cyc(1);
    checks++;
    if ({state, start_ram, finish, score, lives, round_cnt} !== {3'd0, 1'b0, 1'b0, 8'h00, 2'(LI), 8'd0}) begin
      errors++;
      $display("FAIL rst_mid_draw: got state=%0d start=%0b fin=%0b score=%h lives=%0d rnd=%0d",
               state, start_ram, finish, score, lives, round_cnt);
    end
    rst = 1'b0;
    cyc(2);
  endtask

  initial begin
    test_reset;
    test_draw_handshake;
    test_hit;
    test_bcd_and_max_rounds;
    test_lives;
    test_timeout;
    test_reset_mid_draw;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
